// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants, fetch FSM state type and helpers
package core_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Branch/jump opcodes, also decoded by the hazard unit
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } fetch_state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, bubble and hold controls
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc4_d,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  // Load a fetched word, inject a bubble (pc4 kept), or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_INSTR;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_d;
      pc4   <= pc4_d;
      valid <= 1'b1;
    end else if (bubble) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage_pipe.sv
// rtl/if_stage_pipe.sv - instruction fetch stage (PC, fetch FSM, IF/ID); IF_STAGE_PERF_EN adds perf counters
module if_stage_pipe #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush_ifid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
`ifdef IF_STAGE_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_imiss_cnt,
`endif
  output logic [31:0] pc
);

  import core_pkg::*;

  fetch_state_t state;
  logic         req_q;
  logic         drop_q;
  logic [31:0]  pc_q;
  logic         active;
  logic         rdy;
  logic         ifid_load;
  logic         ifid_bubble;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_aligned;

  // After a redirect cancels an outstanding request, the next imem_ready
  // belongs to the old address and is ignored.
  assign active           = (state != BOOT);
  assign rdy              = imem_ready && !drop_q;
  assign pc_plus4         = pc_q + PC_STEP;
  assign redirect_aligned = redirect_pc & ~32'h3;
  assign ifid_load        = active && !stall && !flush_ifid && rdy;
  assign ifid_bubble      = active && !stall && !ifid_load;

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;

  // Fetch FSM and PC: stall > redirect > sequential advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      req_q  <= 1'b0;
      drop_q <= 1'b0;
      pc_q   <= RESET_PC & ~32'h3;
    end else begin
      case (state)
        BOOT: begin
          state  <= FETCH;
          req_q  <= 1'b1;
          drop_q <= 1'b0;
        end
        default: begin
          req_q  <= 1'b1;
          drop_q <= 1'b0;
          if (stall) begin
            if (state == WAIT && imem_ready) state <= FETCH;
          end else if (redirect_valid) begin
            pc_q   <= redirect_aligned;
            state  <= FETCH;
            drop_q <= !rdy;
          end else begin
            if (rdy && !flush_ifid) pc_q <= pc_plus4;
            state <= rdy ? FETCH : WAIT;
          end
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ifid_load),
    .bubble  (ifid_bubble),
    .instr_d (imem_rdata),
    .pc4_d   (pc_plus4),
    .instr   (ifid_instr),
    .pc4     (ifid_pc4),
    .valid   (ifid_valid)
  );

`ifdef IF_STAGE_PERF_EN
  // Saturating event counters; BOOT cycles are not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 32'h0;
      perf_flush_cnt <= 32'h0;
      perf_imiss_cnt <= 32'h0;
    end else if (active) begin
      if (stall)               perf_stall_cnt <= sat_inc(perf_stall_cnt);
      if (flush_ifid && !stall) perf_flush_cnt <= sat_inc(perf_flush_cnt);
      if (state == WAIT)       perf_imiss_cnt <= sat_inc(perf_imiss_cnt);
    end
  end
`endif

endmodule
